// File: rtl/array_arbiter_pkg.sv
// Shared types and helpers for the array arbiter.
// Slot numbering and the rotating-priority pick.
package array_arbiter_pkg;

  localparam int ADDR_N = 11;
  localparam int INT_N  = 32;

  typedef enum logic [1:0] {
    SLOT_W0 = 2'd0,
    SLOT_R0 = 2'd1,
    SLOT_W1 = 2'd2,
    SLOT_R1 = 2'd3
  } slot_e;

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } pick_t;

  // First eligible slot scanning ptr, ptr+1, ... (mod 4).
  function automatic pick_t rr_pick(
    input logic [3:0] elig,
    input logic [1:0] ptr
  );
    pick_t      res;
    logic [1:0] idx;
    res = '0;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (elig[idx]) begin
        res.hit = 1'b1;
        res.idx = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/array_arbiter_if.sv
// Client streams and array port of the arbiter.
// master = clients + array, slave = arbiter.
interface array_arbiter_if
  import array_arbiter_pkg::*;
#(
  parameter int AN = ADDR_N,
  parameter int DN = INT_N
);
  logic [AN-1:0] rA0, rA1;
  logic          rA0_valid, rA1_valid;
  logic          rA0_ready, rA1_ready;
  logic [DN-1:0] r0, r1;
  logic          r0_valid, r1_valid;
  logic          r0_ready, r1_ready;
  logic [AN-1:0] wA0, wA1;
  logic          wA0_valid, wA1_valid;
  logic          wA0_ready, wA1_ready;
  logic [DN-1:0] w0, w1;
  logic          w0_valid, w1_valid;
  logic          w0_ready, w1_ready;
  logic          b0_valid, b1_valid;
  logic          b0_ready, b1_ready;
  logic [AN-1:0] arr_addr;
  logic          arr_we;
  logic [DN-1:0] arr_di;
  logic [DN-1:0] arr_do;

  modport master (
    output rA0, rA0_valid, rA1, rA1_valid,
    input  rA0_ready, rA1_ready,
    input  r0, r0_valid, r1, r1_valid,
    output r0_ready, r1_ready,
    output wA0, wA0_valid, wA1, wA1_valid,
    input  wA0_ready, wA1_ready,
    output w0, w0_valid, w1, w1_valid,
    input  w0_ready, w1_ready,
    input  b0_valid, b1_valid,
    output b0_ready, b1_ready,
    input  arr_addr, arr_we, arr_di,
    output arr_do
  );

  modport slave (
    input  rA0, rA0_valid, rA1, rA1_valid,
    output rA0_ready, rA1_ready,
    output r0, r0_valid, r1, r1_valid,
    input  r0_ready, r1_ready,
    input  wA0, wA0_valid, wA1, wA1_valid,
    output wA0_ready, wA1_ready,
    input  w0, w0_valid, w1, w1_valid,
    output w0_ready, w1_ready,
    output b0_valid, b1_valid,
    input  b0_ready, b1_ready,
    output arr_addr, arr_we, arr_di,
    input  arr_do
  );

endinterface

// File: rtl/array_client_port.sv
// Per-client response state: read in flight,
// read-data slot and write-acknowledge slot.
module array_client_port
  import array_arbiter_pkg::*;
#(
  parameter int DN = INT_N
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_gnt,
  input  logic          rd_gnt,
  input  logic          b_ready,
  input  logic          r_ready,
  input  logic [DN-1:0] arr_do,
  output logic          inflight,
  output logic          b_valid,
  output logic          r_valid,
  output logic [DN-1:0] r
);

  // A read occupies exactly one cycle while the array answers.
  always_ff @(posedge clk) begin
    if (rst) inflight <= 1'b0;
    else     inflight <= rd_gnt;
  end

  // Capture array data in the in-flight cycle; hold until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r       <= '0;
    end else if (inflight) begin
      r_valid <= 1'b1;
      r       <= arr_do;
    end else if (r_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Write acknowledge raised after each write grant.
  always_ff @(posedge clk) begin
    if (rst)          b_valid <= 1'b0;
    else if (wr_gnt)  b_valid <= 1'b1;
    else if (b_ready) b_valid <= 1'b0;
  end

endmodule

// File: rtl/array_arbiter.sv
// Two-client, single-port array arbiter with
// rotating priority over four request slots.
module array_arbiter
  import array_arbiter_pkg::*;
#(
  parameter int AN = ADDR_N,
  parameter int DN = INT_N
) (
  input logic            clk,
  input logic            rst,
  array_arbiter_if.slave bus
);

  logic [3:0]    elig;
  logic [3:0]    gnt;
  logic [1:0]    ptr;
  pick_t         pick;
  logic [AN-1:0] addr_q;
  logic [DN-1:0] di_q;
  logic [1:0]    inflight;
  logic [1:0]    b_valid;
  logic [1:0]    r_valid;

  // Slot eligibility from request valids and response room.
  always_comb begin
    elig          = '0;
    elig[SLOT_W0] = bus.wA0_valid & bus.w0_valid
                  & (~b_valid[0] | bus.b0_ready);
    elig[SLOT_R0] = bus.rA0_valid & ~inflight[0]
                  & (~r_valid[0] | bus.r0_ready);
    elig[SLOT_W1] = bus.wA1_valid & bus.w1_valid
                  & (~b_valid[1] | bus.b1_ready);
    elig[SLOT_R1] = bus.rA1_valid & ~inflight[1]
                  & (~r_valid[1] | bus.r1_ready);
  end

  assign pick = rr_pick(elig, ptr);

  // One-hot grant, suppressed during reset.
  always_comb begin
    gnt = '0;
    if (pick.hit && !rst) gnt[pick.idx] = 1'b1;
  end

  assign bus.wA0_ready = gnt[SLOT_W0];
  assign bus.w0_ready  = gnt[SLOT_W0];
  assign bus.rA0_ready = gnt[SLOT_R0];
  assign bus.wA1_ready = gnt[SLOT_W1];
  assign bus.w1_ready  = gnt[SLOT_W1];
  assign bus.rA1_ready = gnt[SLOT_R1];

  // Priority moves past the last winner; idle cycles keep it.
  always_ff @(posedge clk) begin
    if (rst)       ptr <= 2'd0;
    else if (|gnt) ptr <= pick.idx + 2'd1;
  end

  // Array port mux; address and data hold when idle.
  always_comb begin
    bus.arr_addr = addr_q;
    bus.arr_di   = di_q;
    bus.arr_we   = 1'b0;
    unique case (1'b1)
      gnt[SLOT_W0]: begin
        bus.arr_addr = bus.wA0;
        bus.arr_di   = bus.w0;
        bus.arr_we   = 1'b1;
      end
      gnt[SLOT_R0]: bus.arr_addr = bus.rA0;
      gnt[SLOT_W1]: begin
        bus.arr_addr = bus.wA1;
        bus.arr_di   = bus.w1;
        bus.arr_we   = 1'b1;
      end
      gnt[SLOT_R1]: bus.arr_addr = bus.rA1;
      default: ;
    endcase
  end

  // Remember the last presented address and data.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      di_q   <= '0;
    end else begin
      addr_q <= bus.arr_addr;
      di_q   <= bus.arr_di;
    end
  end

  array_client_port #(.DN(DN)) u_port0 (
    .clk      (clk),
    .rst      (rst),
    .wr_gnt   (gnt[SLOT_W0]),
    .rd_gnt   (gnt[SLOT_R0]),
    .b_ready  (bus.b0_ready),
    .r_ready  (bus.r0_ready),
    .arr_do   (bus.arr_do),
    .inflight (inflight[0]),
    .b_valid  (b_valid[0]),
    .r_valid  (r_valid[0]),
    .r        (bus.r0)
  );

  array_client_port #(.DN(DN)) u_port1 (
    .clk      (clk),
    .rst      (rst),
    .wr_gnt   (gnt[SLOT_W1]),
    .rd_gnt   (gnt[SLOT_R1]),
    .b_ready  (bus.b1_ready),
    .r_ready  (bus.r1_ready),
    .arr_do   (bus.arr_do),
    .inflight (inflight[1]),
    .b_valid  (b_valid[1]),
    .r_valid  (r_valid[1]),
    .r        (bus.r1)
  );

  assign bus.b0_valid = b_valid[0];
  assign bus.b1_valid = b_valid[1];
  assign bus.r0_valid = r_valid[0];
  assign bus.r1_valid = r_valid[1];

endmodule

// File: tb/tb_array_arbiter.sv
// Randomized bench for array_arbiter: behavioural model
// of arbitration and array, with a read-data scoreboard.
module tb_array_arbiter;

  localparam int AN = 11;
  localparam int DN = 32;
  localparam int MS = 1 << AN;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  array_arbiter_if #(.AN(AN), .DN(DN)) bus ();

  array_arbiter #(.AN(AN), .DN(DN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [DN-1:0] init_val(input int a);
    return 32'h8000_0000 | DN'(a);
  endfunction

  // The array itself: registered read, write at posedge.
  logic [DN-1:0] mem [0:MS-1];
  always @(posedge clk) begin
    if (rst) begin
      bus.arr_do <= '0;
      for (int i = 0; i < MS; i++) mem[i] <= init_val(i);
    end else begin
      bus.arr_do <= mem[bus.arr_addr];
      if (bus.arr_we) mem[bus.arr_addr] <= bus.arr_di;
    end
  end

  // Reference model state.
  int            mp;
  bit            m_infl [2];
  bit            m_rv   [2];
  bit            m_bv   [2];
  logic [DN-1:0] mmem   [0:MS-1];
  logic [AN-1:0] m_addr;
  logic [DN-1:0] m_di;
  logic [DN-1:0] expq0 [$];
  logic [DN-1:0] expq1 [$];
  int            gcount [4];
  bit            hs_w [2];
  bit            hs_r [2];

  // Model: predict grant and response valids each cycle.
  always @(negedge clk) begin : model
    bit el [4];
    int g;
    bit rdy [2];
    hs_w[0] = bus.wA0_valid && bus.wA0_ready;
    hs_w[1] = bus.wA1_valid && bus.wA1_ready;
    hs_r[0] = bus.rA0_valid && bus.rA0_ready;
    hs_r[1] = bus.rA1_valid && bus.rA1_ready;
    if (rst) begin
      chk("rst_ready_w0", {bus.wA0_ready, bus.w0_ready}, 0);
      chk("rst_ready_w1", {bus.wA1_ready, bus.w1_ready}, 0);
      chk("rst_ready_r", {bus.rA0_ready, bus.rA1_ready}, 0);
      chk("rst_arr_we", bus.arr_we, 0);
      mp = 0;
      for (int k = 0; k < 2; k++) begin
        m_infl[k] = 0; m_rv[k] = 0; m_bv[k] = 0;
      end
      m_addr = '0;
      m_di = '0;
      expq0.delete();
      expq1.delete();
      for (int i = 0; i < MS; i++) mmem[i] = init_val(i);
    end else begin
      chk("b0_valid", bus.b0_valid, m_bv[0]);
      chk("b1_valid", bus.b1_valid, m_bv[1]);
      chk("r0_valid", bus.r0_valid, m_rv[0]);
      chk("r1_valid", bus.r1_valid, m_rv[1]);
      el[0] = bus.wA0_valid && bus.w0_valid
           && (!m_bv[0] || bus.b0_ready);
      el[1] = bus.rA0_valid && !m_infl[0]
           && (!m_rv[0] || bus.r0_ready);
      el[2] = bus.wA1_valid && bus.w1_valid
           && (!m_bv[1] || bus.b1_ready);
      el[3] = bus.rA1_valid && !m_infl[1]
           && (!m_rv[1] || bus.r1_ready);
      g = -1;
      for (int i = 0; i < 4; i++)
        if (g < 0 && el[(mp + i) % 4]) g = (mp + i) % 4;
      chk("wA0_ready", bus.wA0_ready, g == 0);
      chk("w0_ready", bus.w0_ready, g == 0);
      chk("rA0_ready", bus.rA0_ready, g == 1);
      chk("wA1_ready", bus.wA1_ready, g == 2);
      chk("w1_ready", bus.w1_ready, g == 2);
      chk("rA1_ready", bus.rA1_ready, g == 3);
      chk("arr_we", bus.arr_we, g == 0 || g == 2);
      case (g)
        0: begin m_addr = bus.wA0; m_di = bus.w0; end
        1: m_addr = bus.rA0;
        2: begin m_addr = bus.wA1; m_di = bus.w1; end
        3: m_addr = bus.rA1;
        default: ;
      endcase
      chk("arr_addr", bus.arr_addr, m_addr);
      if (g != 1 && g != 3) chk("arr_di", bus.arr_di, m_di);
      if (g == 0 || g == 2) mmem[m_addr] = m_di;
      if (g == 1) expq0.push_back(mmem[m_addr]);
      if (g == 3) expq1.push_back(mmem[m_addr]);
      rdy[0] = bus.r0_ready;
      rdy[1] = bus.r1_ready;
      m_bv[0] = (g == 0) || (m_bv[0] && !bus.b0_ready);
      m_bv[1] = (g == 2) || (m_bv[1] && !bus.b1_ready);
      for (int k = 0; k < 2; k++) begin
        m_rv[k] = m_infl[k] || (m_rv[k] && !rdy[k]);
        m_infl[k] = (g == 2 * k + 1);
      end
      if (g >= 0) begin
        mp = (g + 1) % 4;
        gcount[g]++;
      end
    end
  end

  // Scoreboard: every presented read word matches the model.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.r0_valid) begin
        if (expq0.size() == 0) chk("r0_unexpected", 1, 0);
        else begin
          chk("r0_data", bus.r0, expq0[0]);
          if (bus.r0_ready) void'(expq0.pop_front());
        end
      end
      if (bus.r1_valid) begin
        if (expq1.size() == 0) chk("r1_unexpected", 1, 0);
        else begin
          chk("r1_data", bus.r1, expq1[0]);
          if (bus.r1_ready) void'(expq1.pop_front());
        end
      end
    end
  end

  // Driver configuration (percentages).
  int pv [4];
  int p_rd [2];
  int p_b [2];
  bit seq_mode = 0;
  int wseq = 0;

  function automatic bit roll(input int p);
    return $urandom_range(0, 99) < p;
  endfunction

  function automatic logic [AN-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return AN'($urandom);
    return AN'($urandom_range(0, 15));
  endfunction

  task automatic cfg(input int w0, r0, w1, r1,
                     input int rd0, rd1, bk0, bk1);
    pv[0] = w0; pv[1] = r0; pv[2] = w1; pv[3] = r1;
    p_rd[0] = rd0; p_rd[1] = rd1;
    p_b[0] = bk0; p_b[1] = bk1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wA0_valid = 0; bus.w0_valid = 0; bus.rA0_valid = 0;
    bus.wA1_valid = 0; bus.w1_valid = 0; bus.rA1_valid = 0;
    bus.r0_ready = 1; bus.r1_ready = 1;
    bus.b0_ready = 1; bus.b1_ready = 1;
    repeat (3) tick();
  endtask

  // Retire handshaken requests and raise new ones at random.
  task automatic drive_step();
    bit more;
    if (hs_w[0]) begin
      bus.wA0_valid = 0; bus.w0_valid = 0;
      if (seq_mode) wseq++;
    end
    if (hs_w[1]) begin bus.wA1_valid = 0; bus.w1_valid = 0; end
    if (hs_r[0]) bus.rA0_valid = 0;
    if (hs_r[1]) bus.rA1_valid = 0;
    more = !seq_mode || wseq < 1024;
    if (!bus.wA0_valid && more && roll(pv[0])) begin
      bus.wA0_valid = 1;
      bus.wA0 = seq_mode ? AN'(wseq) : rnd_addr();
    end
    if (!bus.w0_valid && more && roll(pv[0])) begin
      bus.w0_valid = 1;
      bus.w0 = seq_mode ? DN'(wseq) : DN'($urandom);
    end
    if (!bus.wA1_valid && roll(pv[2])) begin
      bus.wA1_valid = 1; bus.wA1 = rnd_addr();
    end
    if (!bus.w1_valid && roll(pv[2])) begin
      bus.w1_valid = 1; bus.w1 = DN'($urandom);
    end
    if (!bus.rA0_valid && roll(pv[1])) begin
      bus.rA0_valid = 1; bus.rA0 = rnd_addr();
    end
    if (!bus.rA1_valid && roll(pv[3])) begin
      bus.rA1_valid = 1;
      bus.rA1 = seq_mode ? AN'($urandom_range(0, 1023))
                         : rnd_addr();
    end
    bus.r0_ready = roll(p_rd[0]);
    bus.r1_ready = roll(p_rd[1]);
    bus.b0_ready = roll(p_b[0]);
    bus.b1_ready = roll(p_b[1]);
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      tick();
      drive_step();
    end
  endtask

  // Wait (bounded) for a handshake on slot s.
  task automatic wait_grant(input int s, input string nm);
    bit ok = 0;
    for (int c = 0; c < 20 && !ok; c++) begin
      tick();
      case (s)
        0: ok = hs_w[0];
        1: ok = hs_r[0];
        2: ok = hs_w[1];
        default: ok = hs_r[1];
      endcase
    end
    chk(nm, ok, 1);
  endtask

  initial begin : stim
    int g0 [4];
    for (int i = 0; i < 4; i++) gcount[i] = 0;
    bus.wA0 = '0; bus.w0 = '0; bus.rA0 = '0;
    bus.wA1 = '0; bus.w1 = '0; bus.rA1 = '0;
    cfg(0, 0, 0, 0, 100, 100, 100, 100);
    rst = 1;
    idle();
    rst = 0;
    tick();
    chk("post_rst_b0", bus.b0_valid, 0);
    chk("post_rst_r0", bus.r0_valid, 0);

    // Write 77 to address 5, then read it back.
    bus.wA0 = 5; bus.w0 = 77;
    bus.wA0_valid = 1; bus.w0_valid = 1;
    wait_grant(0, "wr5_grant");
    bus.wA0_valid = 0; bus.w0_valid = 0;
    chk("wr5_b0_next", bus.b0_valid, 1);
    bus.rA0 = 5; bus.rA0_valid = 1;
    wait_grant(1, "rd5_grant");
    bus.rA0_valid = 0;
    chk("rd5_lat1", bus.r0_valid, 0);
    tick();
    chk("rd5_lat2", bus.r0_valid, 1);
    chk("rd5_data", bus.r0, 77);
    idle();

    // Everyone requesting, all downstream ready.
    for (int i = 0; i < 4; i++) g0[i] = gcount[i];
    cfg(100, 100, 100, 100, 100, 100, 100, 100);
    run(60);
    for (int i = 0; i < 4; i++)
      chk($sformatf("no_starve_%0d", i), gcount[i] > g0[i], 1);
    idle();

    // Read1 consumer stalled; write1 keeps flowing.
    for (int i = 0; i < 4; i++) g0[i] = gcount[i];
    cfg(0, 0, 100, 100, 100, 0, 100, 100);
    run(20);
    chk("stall_r1_grants", gcount[3] - g0[3], 1);
    chk("stall_w1_flow", gcount[2] - g0[2] > 10, 1);
    idle();

    // Write address without data never wins.
    bus.wA0 = 9; bus.wA0_valid = 1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("wA0_only_ready", bus.wA0_ready, 0);
    end
    idle();

    // Reset while a read is in flight.
    bus.rA0 = 7; bus.rA0_valid = 1;
    wait_grant(1, "rd7_grant");
    bus.rA0_valid = 0;
    rst = 1;
    tick();
    rst = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("rst_drop_r0", bus.r0_valid, 0);
    end

    // Sequential writes by client 0, random reads by client 1.
    idle();
    seq_mode = 1;
    wseq = 0;
    cfg(60, 0, 0, 60, 70, 70, 70, 70);
    for (int c = 0; c < 20000 && wseq < 1024; c++) begin
      tick();
      drive_step();
    end
    chk("seq_writes_done", wseq, 1024);
    seq_mode = 0;
    idle();

    // Free-running random traffic.
    cfg(50, 50, 50, 50, 60, 60, 60, 60);
    run(1500);
    idle();
    repeat (4) tick();
    chk("drain_q0", expq0.size(), 0);
    chk("drain_q1", expq1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/array_arbiter.md
ARRAY_ARBITER -- requirements
Module: array_arbiter

Interface
REQ-001 Parameter AN, default 11, array address width.
REQ-002 Parameter DN, default 32, array data width.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  sole clock; all state updates on posedge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 rA<k>, rA<k>_valid, rA<k>_ready (k=0,1)  in/in/out  AN/1/1  client k read-address stream.
REQ-007 r<k>, r<k>_valid, r<k>_ready  out/out/in  DN/1/1  client k read-data stream.
REQ-008 wA<k>, wA<k>_valid, wA<k>_ready  in/in/out  AN/1/1  client k write-address stream.
REQ-009 w<k>, w<k>_valid, w<k>_ready  in/in/out  DN/1/1  client k write-data stream.
REQ-010 b<k>_valid, b<k>_ready  out/in  1/1  client k write-acknowledge null stream.
REQ-011 arr_addr, arr_we, arr_di  out  AN/1/DN  single array port; write at posedge when arr_we=1.
REQ-012 arr_do  in  DN  array read data, valid the cycle after the address is presented.

Function
REQ-013 Request slots SHALL be indexed 0=write0, 1=read0, 2=write1, 3=read1.
REQ-014 Write slot k SHALL be eligible iff wA<k>_valid && w<k>_valid && (!b<k>_valid || b<k>_ready).
REQ-015 Read slot k SHALL be eligible iff rA<k>_valid && !inflight<k> && (!r<k>_valid || r<k>_ready).
REQ-016 At most one slot SHALL be granted per cycle: the first eligible slot scanning p, p+1, p+2, p+3 (mod 4).
REQ-017 After a grant to slot g, p SHALL become (g+1) mod 4; p SHALL NOT change on idle cycles.
REQ-018 Grant SHALL be combinational in the same cycle; rA<k>_ready, wA<k>_ready, w<k>_ready SHALL be high only in the cycle their slot is granted, and wA<k>_ready equals w<k>_ready.
REQ-019 On a write grant: arr_addr=wA<k>, arr_di=w<k>, arr_we=1; b<k>_valid SHALL be 1 from the next cycle until b<k>_valid && b<k>_ready.
REQ-020 On a read grant: arr_addr=rA<k>, arr_we=0; inflight<k> SHALL be set next cycle; in that cycle arr_do SHALL be captured into r<k>, inflight<k> cleared, and r<k>_valid set the following cycle (grant-to-valid latency 2).
REQ-021 r<k> and r<k>_valid SHALL hold stable while r<k>_valid && !r<k>_ready.
REQ-022 With no grant, arr_we SHALL be 0 and arr_addr/arr_di SHALL hold their previous values.
REQ-023 Operations SHALL take effect in grant order; a read granted after a write to the same address SHALL return the written data.
REQ-024 Data SHALL pass unmodified; bit DN-1 (invalid marker) receives no special treatment.
REQ-025 Throughput: each client SHALL sustain one read per 2 cycles and one write per cycle when its downstream is ready and unopposed.

Reset
REQ-026 While rst=1 at posedge: p=0, inflight<k>=0, r<k>_valid=0, b<k>_valid=0, r<k>=0, arr_addr=0, arr_di=0.
REQ-027 During rst=1, all ready outputs and arr_we SHALL be 0; in-flight reads SHALL be discarded.
REQ-028 After reset deassertion, arbitration SHALL resume the following cycle with p=0.

Structure
REQ-029 Width defaults (`addrN, `intN) and the stream signal-group macros SHALL come from the shared primitives header.
REQ-030 Per-client response state (inflight, r slot, b slot) SHALL live in one sub-module, array_client_port, instantiated twice.

Verification
REQ-031 Reset, then write0 addr 5 data 77, then read0 addr 5 -> b0_valid one cycle after the write grant; r0=77 with r0_valid two cycles after the read grant.
REQ-032 Both clients hold write and read valid continuously with all readys high -> grant sequence 0,1,2,3,0,... (reads skipped while inflight); no slot starves.
REQ-033 r1_ready held low for 10 cycles after a read1 completes -> r1 stable; no further read1 grants; write1 still granted.
REQ-034 wA0_valid high, w0_valid low -> write0 never granted; wA0_ready stays 0.
REQ-035 rst asserted the cycle after a read0 grant -> r0_valid never asserts; p=0 and all valids 0 after reset.
REQ-036 1024 random-stall writes (addr=data=i) by client 0 interleaved with client-1 reads of the same addresses -> each read returns either the init value (bit 31 set) or i.
